// File: rtl/morse_pkg.sv
// Shared Morse definitions: one-hot FSM states, element/gap lengths in units,
// and code classification helpers used by the transmitter (and later the receiver).
package morse_pkg;

  typedef enum logic [4:0] {
    S_IDLE     = 5'b00001,
    S_KEY_ON   = 5'b00010,
    S_ELEM_GAP = 5'b00100,
    S_CHAR_GAP = 5'b01000,
    S_WORD_GAP = 5'b10000
  } state_e;

  localparam logic [2:0] DOT_UNITS        = 3'd1;
  localparam logic [2:0] DASH_UNITS       = 3'd3;
  localparam logic [2:0] ELEM_GAP_UNITS   = 3'd1;
  localparam logic [2:0] CHAR_GAP_UNITS   = 3'd3;
  localparam logic [2:0] WORD_EXTRA_UNITS = 3'd4;

  localparam logic [2:0] MAX_ELEMS  = 3'd5;
  localparam logic [5:0] SPACE_CODE = 6'b100000;

  function automatic logic is_space(input logic [5:0] data);
    return (data & SPACE_CODE) == SPACE_CODE;
  endfunction

  // A space wins over any element count, so only non-space codes can be malformed.
  function automatic logic is_malformed(input logic [5:0] data, input logic [2:0] len);
    return !is_space(data) && ((len == 3'd0) || (len > MAX_ELEMS));
  endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Morse unit timer: counts clock cycles into units and reports how many whole
// units have elapsed since the last clear.
module morse_unit_timer #(
  parameter int unsigned UNIT_CYCLES = 10_000_000
) (
  input  logic       clk_100MHz,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       start,
  output logic       unit_tick,
  output logic [2:0] units_elapsed
);

  localparam int unsigned CW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_CYCLE = CW'(UNIT_CYCLES - 1);

  logic [CW-1:0] cyc_q, cyc_d;
  logic [2:0]    units_q, units_d;

  assign unit_tick     = start && (cyc_q == LAST_CYCLE);
  assign units_elapsed = units_q;

  always_comb begin
    cyc_d   = cyc_q;
    units_d = units_q;
    if (clear) begin
      cyc_d   = '0;
      units_d = '0;
    end else if (start) begin
      if (cyc_q == LAST_CYCLE) begin
        cyc_d = '0;
        // Saturate so a stalled consumer never sees the count wrap back to zero.
        if (units_q != 3'd7) begin
          units_d = units_q + 3'd1;
        end
      end else begin
        cyc_d = cyc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (!reset_n) begin
      cyc_q   <= '0;
      units_q <= '0;
    end else begin
      cyc_q   <= cyc_d;
      units_q <= units_d;
    end
  end

endmodule

// File: rtl/morse_tx.sv
// Morse transmitter: takes one character code per valid/ready handshake and keys
// it out with dot/dash/gap timing derived from an internal unit timer.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   IDLE     | ready for a code; malformed codes are dropped here with tx_err
//   KEY_ON   | key high for 1 unit (dot) or 3 units (dash) of element bit 0
//   ELEM_GAP | key low 1 unit between elements, then advance to next element
//   CHAR_GAP | key low 3 units after the last element
//   WORD_GAP | key low 4 extra units for a word space
module morse_tx
  import morse_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES = 10_000_000
) (
  input  logic       clk_100MHz,
  input  logic       reset_n,
  input  logic [5:0] char_data,
  input  logic [2:0] char_len,
  input  logic       char_valid,
  output logic       char_ready,
  output logic       key_out,
  output logic       busy,
  output logic       tx_err
);

  state_e     state_q, state_d;
  logic [4:0] shift_q, shift_d;
  logic [2:0] cnt_q, cnt_d;
  logic       key_q, key_d;
  logic       ready_q, ready_d;
  logic       busy_q, busy_d;
  logic       err_q, err_d;

  logic       unit_tick;
  logic [2:0] units_elapsed;
  logic [2:0] target_units;
  logic       unit_done;
  logic       timer_clear;
  logic       timer_start;

  // Every state change restarts the unit count, so each state times from zero.
  assign timer_clear = (state_d != state_q);
  assign timer_start = (state_q != S_IDLE);

  morse_unit_timer #(
    .UNIT_CYCLES (UNIT_CYCLES)
  ) u_timer (
    .clk_100MHz    (clk_100MHz),
    .reset_n       (reset_n),
    .clear         (timer_clear),
    .start         (timer_start),
    .unit_tick     (unit_tick),
    .units_elapsed (units_elapsed)
  );

  always_comb begin
    target_units = DOT_UNITS;
    case (state_q)
      S_KEY_ON:   target_units = shift_q[0] ? DASH_UNITS : DOT_UNITS;
      S_ELEM_GAP: target_units = ELEM_GAP_UNITS;
      S_CHAR_GAP: target_units = CHAR_GAP_UNITS;
      S_WORD_GAP: target_units = WORD_EXTRA_UNITS;
      default:    target_units = DOT_UNITS;
    endcase
  end

  // Exit on the cycle the final unit completes, not one cycle after.
  assign unit_done = unit_tick && (units_elapsed == (target_units - 3'd1));

  always_ff @(posedge clk_100MHz) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      key_q   <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (char_valid && ready_q) begin
          if (is_space(char_data)) begin
            state_d = S_WORD_GAP;
          end else if (is_malformed(char_data, char_len)) begin
            err_d = 1'b1;
          end else begin
            state_d = S_KEY_ON;
            shift_d = char_data[4:0];
            cnt_d   = char_len;
          end
        end
      end
      S_KEY_ON: begin
        if (unit_done) begin
          state_d = (cnt_q > 3'd1) ? S_ELEM_GAP : S_CHAR_GAP;
        end
      end
      S_ELEM_GAP: begin
        if (unit_done) begin
          state_d = S_KEY_ON;
          shift_d = shift_q >> 1;
          cnt_d   = cnt_q - 3'd1;
        end
      end
      S_CHAR_GAP: begin
        if (unit_done) begin
          state_d = S_IDLE;
        end
      end
      S_WORD_GAP: begin
        if (unit_done) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are registered copies of next-state decodes, so they align with state_q.
  always_comb begin
    key_d   = (state_d == S_KEY_ON);
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
  end

  assign char_ready = ready_q;
  assign key_out    = key_q;
  assign busy       = busy_q;
  assign tx_err     = err_q;

endmodule

// File: tb/tb_morse_tx.sv
// Scoreboard bench for morse_tx: the driver pushes expected key pulses and error
// pulses at each handshake; a negedge monitor pops and compares them.
module tb_morse_tx;

  localparam int U = 4;

  logic       clk_100MHz = 1'b0;
  logic       reset_n;
  logic [5:0] char_data;
  logic [2:0] char_len;
  logic       char_valid;
  logic       char_ready;
  logic       key_out;
  logic       busy;
  logic       tx_err;

  always #5 clk_100MHz = ~clk_100MHz;

  morse_tx #(.UNIT_CYCLES(U)) dut (
    .clk_100MHz (clk_100MHz),
    .reset_n    (reset_n),
    .char_data  (char_data),
    .char_len   (char_len),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .key_out    (key_out),
    .busy       (busy),
    .tx_err     (tx_err)
  );

  typedef struct {
    int start;
    int len;
  } pulse_t;

  pulse_t exp_pulses[$];
  int     exp_errs[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk_100MHz) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Expected behaviour of one accepted code; returns cycles to the next accept edge.
  task automatic model_char(input logic [5:0] d, input logic [2:0] l, input int t,
                            output int cost);
    int off;
    int units;
    int u;
    pulse_t p;
    if (d[5]) begin
      cost = 1 + 4 * U;
    end else if (l == 3'd0 || l > 3'd5) begin
      exp_errs.push_back(t);
      cost = 1;
    end else begin
      off   = t;
      units = 0;
      for (int i = 0; i < int'(l); i++) begin
        u       = d[i] ? 3 : 1;
        p.start = off;
        p.len   = u * U;
        exp_pulses.push_back(p);
        off   += (u + 1) * U;
        units += u;
      end
      cost = 1 + U * (units + int'(l) - 1 + 3);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  // trunc>0: the key pulse is expected to be cut to trunc cycles by a reset.
  task automatic send(input logic [5:0] d, input logic [2:0] l, input int trunc,
                      input bit scramble, output int t, output int cost);
    int     n;
    pulse_t p;
    n          = 0;
    char_valid = 1'b1;
    char_data  = d;
    char_len   = l;
    while (!char_ready && n < 2000) begin
      if (scramble) begin
        char_data = 6'(n * 7 + 3);
        char_len  = 3'(n);
      end
      @(negedge clk_100MHz);
      n++;
    end
    cost = 0;
    if (!char_ready) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout actual=0 expected=1 at cycle %0d", cyc);
      char_valid = 1'b0;
      t = -1;
      return;
    end
    char_data = d;
    char_len  = l;
    t         = cyc + 1;
    if (trunc > 0) begin
      p.start = t;
      p.len   = trunc;
      exp_pulses.push_back(p);
    end else begin
      model_char(d, l, t, cost);
    end
    @(posedge clk_100MHz);
    @(negedge clk_100MHz);
    char_valid = 1'b0;
  endtask

  // Monitor
  logic key_prev = 1'b0;
  logic rst_smp  = 1'b0;
  int   cur_start = 0;
  int   cur_len   = -1;

  always @(posedge clk_100MHz) rst_smp <= reset_n;

  always @(negedge clk_100MHz) begin : monitor
    pulse_t p;
    if (key_out && !key_prev) begin
      cur_start = cyc;
      if (exp_pulses.size() == 0) begin
        cur_len = -1;
        check("unexpected_pulse", cyc, -1);
      end else begin
        p       = exp_pulses.pop_front();
        cur_len = p.len;
        check("pulse_start", cyc, p.start);
      end
    end
    if (!key_out && key_prev) begin
      check("pulse_len", cyc - cur_start, cur_len);
    end
    key_prev = key_out;
    if (tx_err === 1'b1) begin
      if (exp_errs.size() == 0) check("unexpected_err", cyc, -1);
      else check("err_cycle", cyc, exp_errs.pop_front());
    end
    if (rst_smp) begin
      check("busy_inverse", int'(busy), int'(!char_ready));
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int t [0:9];
    int c [0:9];
    int tr, cr, tp, cp;
    int n;

    reset_n    = 1'b0;
    char_valid = 1'b0;
    char_data  = '0;
    char_len   = '0;
    repeat (3) @(negedge clk_100MHz);
    check("rst_ready", int'(char_ready), 0);
    check("rst_key",   int'(key_out), 0);
    check("rst_busy",  int'(busy), 0);
    check("rst_err",   int'(tx_err), 0);
    reset_n = 1'b1;
    @(negedge clk_100MHz);
    check("ready_after_release", int'(char_ready), 1);

    // Back-to-back chain, valid held high between codes.
    send(6'b000000, 3'd1, 0, 1'b0, t[0], c[0]);  // E
    send(6'b000010, 3'd2, 0, 1'b0, t[1], c[1]);  // A
    send(6'b000000, 3'd1, 0, 1'b0, t[2], c[2]);  // E
    send(6'b100000, 3'd3, 0, 1'b0, t[3], c[3]);  // space (len ignored)
    send(6'b000000, 3'd1, 0, 1'b0, t[4], c[4]);  // E
    send(6'b000011, 3'd0, 0, 1'b0, t[5], c[5]);  // malformed len 0
    send(6'b000011, 3'd6, 0, 1'b0, t[6], c[6]);  // malformed len 6
    send(6'b011111, 3'd5, 0, 1'b0, t[7], c[7]);  // dash x5
    send(6'b000000, 3'd1, 0, 1'b0, t[8], c[8]);  // E

    check("cost_E",        t[1] - t[0], 17);
    check("cost_A",        t[2] - t[1], 33);
    check("cost_E2",       t[3] - t[2], 17);
    check("cost_space",    t[4] - t[3], 17);
    check("cost_E3",       t[5] - t[4], 17);
    check("cost_bad_len0", t[6] - t[5], 1);
    check("cost_bad_len6", t[7] - t[6], 1);
    check("cost_dash5",    t[8] - t[7], 1 + U * (15 + 4 + 3));
    check("e_space_e_low", t[4] - t[2] - U, 2 * (1 + 4 * U) - U);

    // Reset in the middle of a dash: key high for labels t..t+5 only.
    send(6'b000001, 3'd1, 0, 1'b0, tp, cp);
    n = 0;
    while (!char_ready && n < 2000) begin @(negedge clk_100MHz); n++; end
    send(6'b000001, 3'd1, 6, 1'b0, tr, cr);
    repeat (5) @(negedge clk_100MHz);
    reset_n = 1'b0;
    @(negedge clk_100MHz);
    check("rst_mid_key",   int'(key_out), 0);
    check("rst_mid_ready", int'(char_ready), 0);
    @(negedge clk_100MHz);
    check("rst_hold_ready", int'(char_ready), 0);
    reset_n = 1'b1;
    @(negedge clk_100MHz);
    check("rst_release_ready", int'(char_ready), 1);
    send(6'b000000, 3'd1, 0, 1'b0, t[9], c[9]);
    check("post_rst_accept", t[9], tr + 9);

    // Valid held while busy with junk data; only the data at the handshake is keyed.
    send(6'b000001, 3'd1, 0, 1'b1, tp, cp);
    check("scramble_wait", tp - t[9], 17);
    send(6'b000010, 3'd2, 0, 1'b1, tr, cr);
    check("scramble_wait2", tr - tp, 25);

    n = 0;
    while (!char_ready && n < 2000) begin @(negedge clk_100MHz); n++; end
    repeat (3) @(negedge clk_100MHz);
    check("pulses_left", exp_pulses.size(), 0);
    check("errs_left",   exp_errs.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/morse_tx.md
# morse_tx

Morse transmitter: the send-side counterpart of the button-driven Morse receiver. Accepts one character code at a time over a valid/ready handshake and drives a single keyed output (LED/buzzer) with standard Morse timing. Timing comes from an internal unit timer, not external timer blocks. Character codes use the receiver's convention: bit 5 is the word space, bits 4:0 are the elements, and an explicit element count is supplied.

## Interface
- `UNIT_CYCLES`, default 10_000_000: clock cycles per Morse time unit (100 ms at 100 MHz). Minimum 2.
- `clk_100MHz`  in  1  system clock
- `reset_n`  in  1  reset; one clock domain; synchronous, active-low.
- `char_data`  in  6  [5]=word space; [4:0] elements, LSB sent first, 1=dash, 0=dot
- `char_len`  in  3  element count, 1..5; ignored when char_data[5]=1
- `char_valid`  in  1  upstream has a character
- `char_ready`  out  1  block can accept; high only in IDLE
- `key_out`  out  1  keyed output, registered, high = tone/LED on
- `busy`  out  1  high in any state other than IDLE
- `tx_err`  out  1  one-cycle pulse when a malformed code is dropped

## Operation
- Handshake: transfer on a rising edge with char_valid && char_ready. Upstream holds char_data/char_len stable while valid and not ready. Data is captured into an internal shift register and a length counter on transfer.
- Malformed: char_data[5]=0 and (char_len==0 or char_len>5). Accepted, discarded, tx_err=1 for the following cycle, state stays IDLE. No key activity, no gap.
- Space: char_data[5]=1 takes precedence. Bits 4:0 and char_len are ignored. key_out stays low for WORD_EXTRA_UNITS=4 units. The preceding character's 3-unit gap makes up the 7-unit word gap.
- States:
  - IDLE: ready=1. Valid code → KEY_ON. Space → WORD_GAP. Malformed → IDLE.
  - KEY_ON: key_out=1 for 1 unit (dot) or 3 units (dash), chosen by the current element's bit 0. Then → ELEM_GAP if elements remain, else → CHAR_GAP.
  - ELEM_GAP: key_out=0 for 1 unit, shift right, decrement count, → KEY_ON.
  - CHAR_GAP: key_out=0 for 3 units, → IDLE.
  - WORD_GAP: key_out=0 for 4 units, → IDLE.
  - Illegal encoding → IDLE with key_out=0.
- Unit timer: cycle counter 0..UNIT_CYCLES-1, width $clog2(UNIT_CYCLES). Unit counter up to 4, 3 bits. Both counters clear on every state entry. A state exits on the cycle its final unit completes.

## Timing
- Reset (reset_n=0 at an edge): next cycle state=IDLE, key_out=0, char_ready=0, busy=0, tx_err=0.
  - char_ready rises the first cycle after reset_n=1 is sampled.
  - Reset mid-character aborts immediately. No gap is emitted.
- All outputs come from flops or the state register. No combinational path from inputs to outputs.
- Accept at edge T: key_out=1 from cycle T+1. A dot lasts exactly UNIT_CYCLES cycles; a dash lasts 3·UNIT_CYCLES.
- Per-character cost in cycles, from the accept edge to the next possible accept edge:
  - Single dot: 1 + U·(1+3) = 1 + 4U.
  - General: 1 + U·(Σ element units + (len−1) + 3).
  - Space: 1 + 4U.
  - Malformed: 1.
- busy is the inverse of char_ready outside reset.

## Structure
- morse_pkg holds:
  - the state enum (one-hot, like the receiver);
  - constants DOT_UNITS=1, DASH_UNITS=3, ELEM_GAP_UNITS=1, CHAR_GAP_UNITS=3, WORD_EXTRA_UNITS=4;
  - SPACE_CODE=6'b100000.
  The receiver migrates to this package later.
- One sub-module, morse_unit_timer (params UNIT_CYCLES; inputs clear, start; outputs unit_tick, units_elapsed[2:0]). The FSM compares units_elapsed against the state's target.

## Test plan
All scenarios use UNIT_CYCLES=4.
- 'E' (char_data=6'b000000, len=1), accept at T → key_out high T+1..T+4, low T+5..T+16, char_ready high at T+17.
- 'A' (6'b000010, len=2) → key high 4, low 4, high 12, low 12 cycles; char_ready at T+33.
- 'E', then a space, then 'E' back-to-back with char_valid held high → key low between the dots for exactly 12+16=28 cycles.
- Malformed (6'b000011, len=0) → tx_err=1 at T+1 only, key_out stays 0, char_ready=1 at T+1.
- Malformed (len=6) → same response as len=0.
- Reset pulse in the middle of a dash → key_out=0 the cycle after reset is sampled, char_ready=0 during reset, char_ready=1 the first cycle after release, and the next character is timed normally.
- char_valid high while busy with changing data → no transfer until char_ready; only the data present at the handshake edge is keyed.
